// File: rtl/wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// wb_arbiter_if
// Purpose : Bundles the write-back request bus, the register-file write port
//           and the issue/scoreboard check signals of wb_arbiter.
// Signals :
//   i_req_valid  [NUM_REQ]      requester k has a write pending
//   i_req_addr   [5*NUM_REQ]    destination register of requester k
//   i_req_data   [DATA_W*NREQ]  write data of requester k
//   o_req_ready  [NUM_REQ]      one-hot grant
//   o_rd_addr/o_rd_data/o_rd_wren  registered register-file write port
//   i_issue_valid/i_issue_rd/i_issue_rd_we  issuing instruction
//   i_chk_rs1/i_chk_rs2         sources of the issuing instruction
//   o_stall                     issue must be held this cycle
// Modports: slave = arbiter side, master = execution units / issue side.
// ----------------------------------------------------------------------------
interface wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        i_req_valid;
    logic [5*NUM_REQ-1:0]      i_req_addr;
    logic [DATA_W*NUM_REQ-1:0] i_req_data;
    logic [NUM_REQ-1:0]        o_req_ready;
    logic [4:0]                o_rd_addr;
    logic [DATA_W-1:0]         o_rd_data;
    logic                      o_rd_wren;
    logic                      i_issue_valid;
    logic [4:0]                i_issue_rd;
    logic                      i_issue_rd_we;
    logic [4:0]                i_chk_rs1;
    logic [4:0]                i_chk_rs2;
    logic                      o_stall;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_data,
        input  i_issue_valid, i_issue_rd, i_issue_rd_we, i_chk_rs1, i_chk_rs2,
        output o_req_ready, o_rd_addr, o_rd_data, o_rd_wren, o_stall
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_data,
        output i_issue_valid, i_issue_rd, i_issue_rd_we, i_chk_rs1, i_chk_rs2,
        input  o_req_ready, o_rd_addr, o_rd_data, o_rd_wren, o_stall
    );
endinterface

// File: rtl/wb_arbiter.sv
// ----------------------------------------------------------------------------
// wb_arbiter
// Purpose : Round-robin arbitration of NUM_REQ write-back sources onto the
//           single register-file write port, plus a per-register busy
//           scoreboard that stalls issue on RAW/WAW hazards until the pending
//           write has been presented to the register file.
// Ports   :
//   i_clk    clock, all state updates on the rising edge
//   i_reset  synchronous active-high reset
//   bus      wb_arbiter_if.slave (request bus, rd write port, issue checks)
// ----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    wb_arbiter_if.slave   bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Requester index base+off, wrapped modulo NUM_REQ.
    function automatic logic [PTR_W-1:0] f_wrap_idx(input logic [PTR_W-1:0] base,
                                                     input int off);
        int t;
        t = int'(base) + off;
        if (t >= NUM_REQ) t = t - NUM_REQ;
        return PTR_W'(t);
    endfunction

    // Pointer position just after the granted requester.
    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] g);
        if (int'(g) == NUM_REQ - 1) return '0;
        return g + 1'b1;
    endfunction

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [31:0]        r_busy;
    logic [4:0]         r_rd_addr_p1;
    logic [DATA_W-1:0]  r_rd_data_p1;
    logic               r_rd_wren_p1;

    logic               w_found;
    logic [PTR_W-1:0]   w_gidx;
    logic [PTR_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic [4:0]         w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_stall;
    logic               w_set;
    logic [31:0]        w_busy_nxt;

    // Grant search: first valid requester starting at the round-robin pointer.
    // Reset masks the grant so no handshake completes while it is held.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        w_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = f_wrap_idx(r_rr_ptr, i);
            if (!w_found && bus.i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
        if (i_reset) w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_grant[k] = w_found && (int'(w_gidx) == k);
        end
    end

    assign w_sel_addr = bus.i_req_addr[int'(w_gidx)*5 +: 5];
    assign w_sel_data = bus.i_req_data[int'(w_gidx)*DATA_W +: DATA_W];

    // Hazard check; busy[0] is never set so x0 sources never stall.
    assign w_stall = !i_reset && bus.i_issue_valid &&
                     (r_busy[bus.i_chk_rs1] || r_busy[bus.i_chk_rs2] ||
                      (bus.i_issue_rd_we && r_busy[bus.i_issue_rd]));

    assign w_set = !i_reset && bus.i_issue_valid && bus.i_issue_rd_we &&
                   (bus.i_issue_rd != 5'd0) && !w_stall;

    // Clear first, then set, so a same-cycle set on the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_rd_wren_p1) w_busy_nxt[r_rd_addr_p1] = 1'b0;
        if (w_set)        w_busy_nxt[bus.i_issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Stage p1: register-file write port and arbitration/scoreboard state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr     <= '0;
            r_busy       <= '0;
            r_rd_wren_p1 <= 1'b0;
            r_rd_addr_p1 <= '0;
            r_rd_data_p1 <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_found) begin
                r_rr_ptr     <= f_next_ptr(w_gidx);
                r_rd_addr_p1 <= w_sel_addr;
                r_rd_data_p1 <= w_sel_data;
                r_rd_wren_p1 <= (w_sel_addr != 5'd0);
            end else begin
                r_rd_wren_p1 <= 1'b0;
            end
        end
    end

    assign bus.o_req_ready = w_grant;
    assign bus.o_rd_addr   = r_rd_addr_p1;
    assign bus.o_rd_data   = r_rd_data_p1;
    assign bus.o_rd_wren   = r_rd_wren_p1;
    assign bus.o_stall     = w_stall;
endmodule

// File: tb/tb_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_arbiter
// Purpose : Directed self-checking bench for wb_arbiter (NUM_REQ = 3).
// ----------------------------------------------------------------------------
module tb_wb_arbiter;
    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 32;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    wb_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [4:0] a, input logic [31:0] d);
        bus.i_req_addr[k*5 +: 5]           = a;
        bus.i_req_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_issue(input logic v, input logic we, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2);
        bus.i_issue_valid = v;
        bus.i_issue_rd_we = we;
        bus.i_issue_rd    = rd;
        bus.i_chk_rs1     = rs1;
        bus.i_chk_rs2     = rs2;
    endtask

    logic [2:0]  exp_g [6];
    logic [4:0]  exp_a [6];
    logic [31:0] exp_d [6];

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_a = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
        exp_d = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003,
                  32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

        // Reset held two cycles with every requester valid and an issue pending.
        rst = 1'b1;
        bus.i_req_valid = 3'b111;
        set_req(0, 5'd1, 32'h1111_0001);
        set_req(1, 5'd2, 32'h2222_0002);
        set_req(2, 5'd3, 32'h3333_0003);
        set_issue(1'b1, 1'b1, 5'd5, 5'd3, 5'd4);
        tick();
        tick();
        chk("rst_ready", 32'(bus.o_req_ready), 32'h0);
        chk("rst_stall", 32'(bus.o_stall), 32'h0);
        chk("rst_wren", 32'(bus.o_rd_wren), 32'h0);
        chk("rst_addr", 32'(bus.o_rd_addr), 32'h0);
        chk("rst_data", bus.o_rd_data, 32'h0);

        rst = 1'b0;
        set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("first_grant", 32'(bus.o_req_ready), 32'h1);

        // Round robin with all three valid.
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("rr_ready%0d", c), 32'(bus.o_req_ready), 32'(exp_g[c]));
            tick();
            chk($sformatf("rr_wren%0d", c), 32'(bus.o_rd_wren), 32'h1);
            chk($sformatf("rr_addr%0d", c), 32'(bus.o_rd_addr), 32'(exp_a[c]));
            chk($sformatf("rr_data%0d", c), bus.o_rd_data, exp_d[c]);
        end

        // Move pointer to 1, then valid=101 must skip to requester 2, then 0.
        bus.i_req_valid = 3'b001;
        #1;
        chk("ptr_setup", 32'(bus.o_req_ready), 32'h1);
        tick();
        bus.i_req_valid = 3'b101;
        #1;
        chk("skip_to2", 32'(bus.o_req_ready), 32'h4);
        tick();
        chk("skip_addr2", 32'(bus.o_rd_addr), 32'd3);
        chk("wrap_to0", 32'(bus.o_req_ready), 32'h1);
        tick();
        chk("wrap_addr0", 32'(bus.o_rd_addr), 32'd1);

        // x0 write by requester 1 (pointer now 1).
        bus.i_req_valid = 3'b010;
        set_req(1, 5'd0, 32'hDEAD_BEEF);
        #1;
        chk("x0_ready", 32'(bus.o_req_ready), 32'h2);
        tick();
        chk("x0_wren", 32'(bus.o_rd_wren), 32'h0);
        chk("x0_addr", 32'(bus.o_rd_addr), 32'h0);
        chk("x0_data", bus.o_rd_data, 32'hDEAD_BEEF);
        bus.i_req_valid = 3'b000;

        // RAW / WAW on x5 (pointer now 2).
        set_issue(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
        #1;
        chk("issue5_stall", 32'(bus.o_stall), 32'h0);
        tick();
        set_issue(1'b1, 1'b1, 5'd9, 5'd5, 5'd0);
        #1;
        chk("raw_rs1", 32'(bus.o_stall), 32'h1);
        tick();
        set_issue(1'b1, 1'b0, 5'd0, 5'd0, 5'd5);
        #1;
        chk("raw_rs2", 32'(bus.o_stall), 32'h1);
        set_issue(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
        #1;
        chk("waw_rd", 32'(bus.o_stall), 32'h1);
        set_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        chk("x0_nobusy", 32'(bus.o_stall), 32'h0);
        set_issue(1'b1, 1'b0, 5'd0, 5'd5, 5'd0);
        bus.i_req_valid = 3'b100;
        set_req(2, 5'd5, 32'h5555_0005);
        #1;
        chk("wb5_ready", 32'(bus.o_req_ready), 32'h4);
        chk("stall_N", 32'(bus.o_stall), 32'h1);
        tick();
        bus.i_req_valid = 3'b000;
        chk("wb5_wren", 32'(bus.o_rd_wren), 32'h1);
        chk("wb5_addr", 32'(bus.o_rd_addr), 32'd5);
        chk("wb5_data", bus.o_rd_data, 32'h5555_0005);
        #1;
        chk("stall_N1", 32'(bus.o_stall), 32'h1);
        tick();
        chk("stall_N2", 32'(bus.o_stall), 32'h0);
        chk("wren_off", 32'(bus.o_rd_wren), 32'h0);
        set_issue(1'b1, 1'b0, 5'd0, 5'd9, 5'd0);
        #1;
        chk("stalled_no_set", 32'(bus.o_stall), 32'h0);

        // Set/clear collision on x7 (pointer now 0).
        set_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        bus.i_req_valid = 3'b001;
        set_req(0, 5'd7, 32'h7777_0007);
        #1;
        chk("wb7_ready", 32'(bus.o_req_ready), 32'h1);
        tick();
        bus.i_req_valid = 3'b000;
        chk("wb7_wren", 32'(bus.o_rd_wren), 32'h1);
        chk("wb7_addr", 32'(bus.o_rd_addr), 32'd7);
        set_issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
        #1;
        chk("coll_issue", 32'(bus.o_stall), 32'h0);
        tick();
        set_issue(1'b1, 1'b0, 5'd0, 5'd7, 5'd0);
        #1;
        chk("coll_setwins", 32'(bus.o_stall), 32'h1);
        chk("idle_ready", 32'(bus.o_req_ready), 32'h0);
        set_issue(1'b0, 1'b0, 5'd0, 5'd7, 5'd0);
        #1;
        chk("no_issue_nostall", 32'(bus.o_stall), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
